yutorina_gpr_write_arbiter: RTL and testbench
=============================================

Name: yutorina_gpr_write_arbiter

Overview:
Shares the general-purpose register file's single write port among three sources: the in-order pipeline writeback, load-data return, and the multi-cycle mul/div unit. Load and mul/div results each wait in a one-entry holding slot. The pipeline normally has priority, and a starvation guard forces a held slot through by stalling the pipeline. The block also drives the register file's write port and answers hazard queries ("is a write to register X still pending?") for decode.

Parameters:
DATA_WIDTH, 32, width of a register word
ADDR_WIDTH, 5, register address width
STARVE_LIMIT, 4, cycles a held slot may wait before it pre-empts the pipeline

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
pipe_req  in  1  pipeline writeback request
pipe_addr  in  ADDR_WIDTH  pipeline destination register
pipe_data  in  DATA_WIDTH  pipeline result
pipe_ready  out  1  pipeline request accepted this cycle; low means the pipeline holds req/addr/data and stalls
load_req / load_addr / load_data  in  1 / ADDR_WIDTH / DATA_WIDTH  load-return request
load_ready  out  1  load slot empty
md_req / md_addr / md_data  in  1 / ADDR_WIDTH / DATA_WIDTH  mul/div request
md_ready  out  1  mul/div slot empty
check_addr  in  ADDR_WIDTH  decode hazard query address
check_pending  out  1  a valid slot holds check_addr, and check_addr != 0
gpr_write_enable_  out  1  active-low write enable to the register file
gpr_write_address  out  ADDR_WIDTH  register file write address
gpr_write_data  out  DATA_WIDTH  register file write data

Behaviour:
- Reset (any cycle, including with slots full): clear both slots and wait counters; RR pointer = load. Registered outputs: gpr_write_enable_ = 1 (disabled), gpr_write_address = 0, gpr_write_data = 0.
- Slot state per source: valid, addr, data, wait (0..STARVE_LIMIT).
  - Filled at the edge when req && slot empty && addr != 0; wait = 0.
  - Request with addr == 0 is accepted and discarded; slot is untouched.
  - ready = !valid, combinational from registered state.
- Grant decision, combinational each cycle, in priority order:
  1. A valid slot with wait == STARVE_LIMIT wins. If both starve, the RR pointer picks. pipe_ready = 0.
  2. Else pipe_req wins. pipe_ready = 1.
  3. Else a valid slot wins; if both are valid, the RR pointer picks.
  4. Else idle.
- pipe_ready is 1 whenever no slot is starving, including when pipe_req = 0.
- Write port is registered, 1-cycle latency: the winner's addr/data appear on gpr_write_* with enable_ = 0 during the cycle after the grant edge.
  - A pipe write to addr 0 is granted but produces enable_ = 1.
  - Idle cycle: enable_ = 1; address/data hold their previous values.
- Slot granted: valid clears at the grant edge. A new request to that source is accepted no earlier than the following cycle (ready is from registered state). Minimum load latency is therefore 2 cycles, req to write.
- RR pointer toggles to the other source after every slot grant (starvation grants included); unchanged otherwise.
- Wait counter: +1 each cycle the slot is valid and not granted; saturates at STARVE_LIMIT.
- WAW squash: when the pipe is granted with addr A != 0, any valid, ungranted slot holding A is cleared that edge; the newer pipeline result wins.
- Upstream guarantees load and mul/div never target the same register concurrently; no ordering is enforced between the slots.
- Simultaneous events in one cycle: slot grant plus same-source req → req not accepted (ready was 0). Starvation while pipe_req → pipe stalls exactly one cycle per starved grant.

Decomposition:
- Shared package/header: source encoding (NONE, PIPE, LOAD, MD), active-low enable constants, and reset polarity constants. Widths come from the ISA header.
- Natural sub-module: yutorina_gpr_hold_slot, one instance per source. Holds valid/addr/data/wait, fill/grant/squash inputs, a starving output, and an address-match output used for both squash and check_pending.

Test Plan:
- Reset, then idle → enable_ = 1, address = 0, data = 0, pipe_ready = load_ready = md_ready = 1.
- pipe_req addr = 3, data = 0x11 for one cycle → next cycle enable_ = 0, addr 3, data 0x11.
- load_req addr = 7, data = 0xAA while pipe_req is continuous to addr 1 → load waits; pipe_ready drops exactly at wait = 4; one cycle later the port writes 7/0xAA; pipe resumes.
- Load and md slots both valid, pipe idle → grants alternate load, md, load from reset. Same setup with pipe_req addr = 0 → pipe is granted, enable_ stays 1.
- Load slot holds addr 5; pipe writes addr 5 = 0x22 → slot squashed, load_ready = 1 the next cycle, only 0x22 is written. During the hold, check_addr = 5 → check_pending = 1; check_addr = 0 → 0.
- Reset asserted with both slots full and a starvation stall in progress → next cycle all slots empty, pipe_ready = 1, enable_ = 1, no stale write afterwards.

Source files
------------

// File: rtl/yutorina_gpr_write_arbiter_pkg.sv
// Shared types and constants for the GPR write-port arbiter.
// Covers source encoding, write-enable polarity and reset polarity.
package yutorina_gpr_write_arbiter_pkg;

    typedef enum logic [1:0] {
        SrcNone,
        SrcPipe,
        SrcLoad,
        SrcMd
    } src_e;

    // The register file write enable is active low.
    localparam logic WE_ON  = 1'b0;
    localparam logic WE_OFF = 1'b1;

    localparam logic RESET_ACTIVE = 1'b1;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_ADDR_WIDTH = 5;

endpackage

// File: rtl/yutorina_gpr_hold_slot.sv
// One-entry holding slot for a deferred register write.
// Tracks how long it has waited and reports address matches for squash and hazard queries.
module yutorina_gpr_hold_slot
    import yutorina_gpr_write_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_data_i,
    input  logic                  grant_i,
    input  logic                  squash_i,
    input  logic [ADDR_WIDTH-1:0] squash_addr_i,
    input  logic [ADDR_WIDTH-1:0] check_addr_i,
    output logic                  valid_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  starving_o,
    output logic                  check_hit_o
);

    localparam int unsigned WaitW = $clog2(STARVE_LIMIT + 1);

    logic                  valid_q, valid_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [WaitW-1:0]      wait_q, wait_d;

    assign starving_o  = valid_q && (wait_q == WaitW'(STARVE_LIMIT));
    assign check_hit_o = valid_q && (addr_q == check_addr_i);
    assign valid_o     = valid_q;
    assign addr_o      = addr_q;
    assign data_o      = data_q;

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wait_d  = wait_q;
        if (valid_q) begin
            // A newer pipeline write to the same register makes this entry obsolete.
            if (grant_i || (squash_i && (addr_q == squash_addr_i))) begin
                valid_d = 1'b0;
            end else if (!starving_o) begin
                wait_d = wait_q + WaitW'(1);
            end
        end else if (req_i && (req_addr_i != '0)) begin
            valid_d = 1'b1;
            addr_d  = req_addr_i;
            data_d  = req_data_i;
            wait_d  = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i == RESET_ACTIVE) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            wait_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wait_q  <= wait_d;
        end
    end

endmodule

// File: rtl/yutorina_gpr_write_arbiter.sv
// Arbitrates the GPR file's single write port between pipeline, load return and mul/div.
// Pipeline has priority unless a held slot has starved; also answers decode hazard queries.
module yutorina_gpr_write_arbiter
    import yutorina_gpr_write_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  pipe_req,
    input  logic [ADDR_WIDTH-1:0] pipe_addr,
    input  logic [DATA_WIDTH-1:0] pipe_data,
    output logic                  pipe_ready,
    input  logic                  load_req,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  load_ready,
    input  logic                  md_req,
    input  logic [ADDR_WIDTH-1:0] md_addr,
    input  logic [DATA_WIDTH-1:0] md_data,
    output logic                  md_ready,
    input  logic [ADDR_WIDTH-1:0] check_addr,
    output logic                  check_pending,
    output logic                  gpr_write_enable_,
    output logic [ADDR_WIDTH-1:0] gpr_write_address,
    output logic [DATA_WIDTH-1:0] gpr_write_data
);

    logic                  load_valid, md_valid;
    logic [ADDR_WIDTH-1:0] load_slot_addr, md_slot_addr;
    logic [DATA_WIDTH-1:0] load_slot_data, md_slot_data;
    logic                  load_starve, md_starve;
    logic                  load_hit, md_hit;
    logic                  squash;
    src_e                  grant;
    src_e                  rr_q, rr_d;
    logic                  we_n_q, we_n_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    assign squash = (grant == SrcPipe) && (pipe_addr != '0);

    yutorina_gpr_hold_slot #(
        .DATA_WIDTH  (DATA_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_load_slot (
        .clk_i        (clock),
        .rst_i        (reset),
        .req_i        (load_req),
        .req_addr_i   (load_addr),
        .req_data_i   (load_data),
        .grant_i      (grant == SrcLoad),
        .squash_i     (squash),
        .squash_addr_i(pipe_addr),
        .check_addr_i (check_addr),
        .valid_o      (load_valid),
        .addr_o       (load_slot_addr),
        .data_o       (load_slot_data),
        .starving_o   (load_starve),
        .check_hit_o  (load_hit)
    );

    yutorina_gpr_hold_slot #(
        .DATA_WIDTH  (DATA_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_md_slot (
        .clk_i        (clock),
        .rst_i        (reset),
        .req_i        (md_req),
        .req_addr_i   (md_addr),
        .req_data_i   (md_data),
        .grant_i      (grant == SrcMd),
        .squash_i     (squash),
        .squash_addr_i(pipe_addr),
        .check_addr_i (check_addr),
        .valid_o      (md_valid),
        .addr_o       (md_slot_addr),
        .data_o       (md_slot_data),
        .starving_o   (md_starve),
        .check_hit_o  (md_hit)
    );

    assign load_ready    = !load_valid;
    assign md_ready      = !md_valid;
    assign check_pending = (check_addr != '0) && (load_hit || md_hit);

    always_comb begin
        grant      = SrcNone;
        pipe_ready = 1'b1;
        if (load_starve || md_starve) begin
            pipe_ready = 1'b0;
            if (load_starve && md_starve) begin
                grant = rr_q;
            end else begin
                grant = load_starve ? SrcLoad : SrcMd;
            end
        end else if (pipe_req) begin
            grant = SrcPipe;
        end else if (load_valid && md_valid) begin
            grant = rr_q;
        end else if (load_valid) begin
            grant = SrcLoad;
        end else if (md_valid) begin
            grant = SrcMd;
        end
    end

    always_comb begin
        we_n_d  = WE_OFF;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        rr_d    = rr_q;
        case (grant)
            SrcPipe: begin
                we_n_d  = (pipe_addr == '0) ? WE_OFF : WE_ON;
                waddr_d = pipe_addr;
                wdata_d = pipe_data;
            end
            SrcLoad: begin
                we_n_d  = WE_ON;
                waddr_d = load_slot_addr;
                wdata_d = load_slot_data;
                rr_d    = (rr_q == SrcLoad) ? SrcMd : SrcLoad;
            end
            SrcMd: begin
                we_n_d  = WE_ON;
                waddr_d = md_slot_addr;
                wdata_d = md_slot_data;
                rr_d    = (rr_q == SrcLoad) ? SrcMd : SrcLoad;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset == RESET_ACTIVE) begin
            rr_q    <= SrcLoad;
            we_n_q  <= WE_OFF;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            rr_q    <= rr_d;
            we_n_q  <= we_n_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign gpr_write_enable_ = we_n_q;
    assign gpr_write_address = waddr_q;
    assign gpr_write_data    = wdata_q;

endmodule

// File: tb/tb_yutorina_gpr_write_arbiter.sv
// Directed plus randomized bench for the GPR write arbiter against a per-cycle behavioural model.
module tb_yutorina_gpr_write_arbiter;

    localparam int AW  = 5;
    localparam int DW  = 32;
    localparam int LIM = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          pipe_req, load_req, md_req;
    logic [AW-1:0] pipe_addr, load_addr, md_addr, check_addr;
    logic [DW-1:0] pipe_data, load_data, md_data;
    logic          pipe_ready, load_ready, md_ready, check_pending;
    logic          gpr_write_enable_;
    logic [AW-1:0] gpr_write_address;
    logic [DW-1:0] gpr_write_data;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: index 0 = load slot, 1 = mul/div slot.
    logic          mv[2];
    logic [AW-1:0] ma[2];
    logic [DW-1:0] mdat[2];
    int            mw[2];
    int            mrr;
    logic          m_we_n;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic          last_pr;

    yutorina_gpr_write_arbiter dut (
        .clock            (clock),
        .reset            (reset),
        .pipe_req         (pipe_req),
        .pipe_addr        (pipe_addr),
        .pipe_data        (pipe_data),
        .pipe_ready       (pipe_ready),
        .load_req         (load_req),
        .load_addr        (load_addr),
        .load_data        (load_data),
        .load_ready       (load_ready),
        .md_req           (md_req),
        .md_addr          (md_addr),
        .md_data          (md_data),
        .md_ready         (md_ready),
        .check_addr       (check_addr),
        .check_pending    (check_pending),
        .gpr_write_enable_(gpr_write_enable_),
        .gpr_write_address(gpr_write_address),
        .gpr_write_data   (gpr_write_data)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mv[i] = 1'b0;
            mw[i] = 0;
        end
        mrr    = 0;
        m_we_n = 1'b1;
        m_addr = '0;
        m_data = '0;
    endtask

    // Checks all outputs just before the edge, then advances the model across it.
    task automatic step();
        logic          s0, s1, exp_pr, exp_cp;
        logic          rq[2];
        logic [AW-1:0] ra[2];
        logic [DW-1:0] rd[2];
        int            g;
        @(negedge clock);
        s0     = mv[0] && (mw[0] == LIM);
        s1     = mv[1] && (mw[1] == LIM);
        exp_pr = !(s0 || s1);
        exp_cp = (check_addr != 0) &&
                 ((mv[0] && ma[0] == check_addr) || (mv[1] && ma[1] == check_addr));
        chk("pipe_ready", pipe_ready, exp_pr);
        chk("load_ready", load_ready, !mv[0]);
        chk("md_ready", md_ready, !mv[1]);
        chk("check_pending", check_pending, exp_cp);
        chk("we_n", gpr_write_enable_, m_we_n);
        chk("waddr", gpr_write_address, m_addr);
        chk("wdata", gpr_write_data, m_data);
        last_pr = exp_pr;
        rq[0] = load_req; ra[0] = load_addr; rd[0] = load_data;
        rq[1] = md_req;   ra[1] = md_addr;   rd[1] = md_data;
        if (reset) begin
            model_reset();
        end else begin
            g = -1;
            if (s0 && s1) g = mrr;
            else if (s0) g = 0;
            else if (s1) g = 1;
            else if (pipe_req) g = 2;
            else if (mv[0] && mv[1]) g = mrr;
            else if (mv[0]) g = 0;
            else if (mv[1]) g = 1;
            if (g == 2) begin
                m_we_n = (pipe_addr == 0);
                m_addr = pipe_addr;
                m_data = pipe_data;
            end else if (g >= 0) begin
                m_we_n = 1'b0;
                m_addr = ma[g];
                m_data = mdat[g];
            end else begin
                m_we_n = 1'b1;
            end
            for (int i = 0; i < 2; i++) begin
                if (g == i) begin
                    mv[i] = 1'b0;
                end else if (mv[i]) begin
                    if (g == 2 && pipe_addr != 0 && ma[i] == pipe_addr) mv[i] = 1'b0;
                    else if (mw[i] < LIM) mw[i]++;
                end else if (rq[i] && ra[i] != 0) begin
                    mv[i]   = 1'b1;
                    ma[i]   = ra[i];
                    mdat[i] = rd[i];
                    mw[i]   = 0;
                end
            end
            if (g == 0 || g == 1) mrr = 1 - mrr;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        pipe_req = 0; load_req = 0; md_req = 0;
        pipe_addr = '0; load_addr = '0; md_addr = '0; check_addr = '0;
        pipe_data = '0; load_data = '0; md_data = '0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        @(posedge clock);
        #1;
        model_reset();
        step();
        reset = 1'b0;
        step();
        chk("rst_we", gpr_write_enable_, 1'b1);
        chk("rst_addr", gpr_write_address, 0);
        chk("rst_data", gpr_write_data, 0);

        // Single pipeline write.
        pipe_req = 1; pipe_addr = 3; pipe_data = 32'h11;
        step();
        idle_inputs();
        chk("pipe_we", gpr_write_enable_, 1'b0);
        chk("pipe_addr", gpr_write_address, 3);
        chk("pipe_data", gpr_write_data, 32'h11);
        step();

        // Load starves behind a continuous pipeline stream.
        pipe_req = 1; pipe_addr = 1; pipe_data = 32'h100;
        load_req = 1; load_addr = 7; load_data = 32'hAA;
        step();
        load_req = 0;
        for (int i = 0; i < 4; i++) begin
            pipe_data = pipe_data + 1;
            step();
        end
        chk("starve_stall", pipe_ready, 1'b0);
        step();
        chk("starve_we", gpr_write_enable_, 1'b0);
        chk("starve_addr", gpr_write_address, 7);
        chk("starve_data", gpr_write_data, 32'hAA);
        chk("resume", pipe_ready, 1'b1);
        step();
        idle_inputs();
        step();

        // Round robin between load and mul/div from reset.
        reset = 1; step(); reset = 0;
        load_req = 1; load_addr = 9;  load_data = 32'h99;
        md_req   = 1; md_addr   = 10; md_data   = 32'hA0;
        step();
        idle_inputs();
        step();
        chk("rr_first", gpr_write_address, 9);
        load_req = 1; load_addr = 11; load_data = 32'hB0;
        step();
        chk("rr_second", gpr_write_address, 10);
        idle_inputs();
        step();
        chk("rr_third", gpr_write_address, 11);
        load_req = 1; load_addr = 12; md_req = 1; md_addr = 13;
        step();
        idle_inputs();
        pipe_req = 1; pipe_addr = 0; pipe_data = 32'hDEAD;
        step();
        chk("pipe_zero_we", gpr_write_enable_, 1'b1);
        idle_inputs();
        repeat (3) step();

        // Squash of a held load by a newer pipeline write.
        pipe_req = 1; pipe_addr = 2; pipe_data = 32'h2;
        load_req = 1; load_addr = 5; load_data = 32'h55;
        step();
        load_req = 0;
        check_addr = 5; #1;
        chk("hazard_hit", check_pending, 1'b1);
        check_addr = 0; #1;
        chk("hazard_zero", check_pending, 1'b0);
        step();
        pipe_addr = 5; pipe_data = 32'h22;
        step();
        chk("squash_ready", load_ready, 1'b1);
        chk("squash_addr", gpr_write_address, 5);
        chk("squash_data", gpr_write_data, 32'h22);
        idle_inputs();
        step();
        chk("squash_nowr", gpr_write_enable_, 1'b1);

        // Reset during a double-starvation stall.
        pipe_req = 1; pipe_addr = 1; pipe_data = 32'h7;
        load_req = 1; load_addr = 12; load_data = 32'hC;
        md_req   = 1; md_addr   = 13; md_data   = 32'hD;
        step();
        load_req = 0; md_req = 0;
        repeat (4) step();
        chk("dual_stall", pipe_ready, 1'b0);
        reset = 1;
        step();
        reset = 0;
        chk("rst_load_ready", load_ready, 1'b1);
        chk("rst_md_ready", md_ready, 1'b1);
        chk("rst_pipe_ready", pipe_ready, 1'b1);
        chk("rst_stall_we", gpr_write_enable_, 1'b1);
        idle_inputs();
        repeat (3) step();

        // Randomized traffic; a stalled pipeline holds its request.
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 79) == 0);
            if (!(pipe_req && !last_pr)) begin
                pipe_req  = ($urandom_range(0, 3) != 0);
                pipe_addr = AW'($urandom_range(0, 7));
                pipe_data = $urandom;
            end
            load_req   = ($urandom_range(0, 2) == 0);
            load_addr  = AW'($urandom_range(0, 7));
            load_data  = $urandom;
            md_req     = ($urandom_range(0, 2) == 0);
            md_addr    = AW'($urandom_range(0, 7));
            md_data    = $urandom;
            check_addr = AW'($urandom_range(0, 7));
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
